// File: rtl/mem_arb_pkg.sv
// Shared definitions for the multicycle memory arbiter.
//   state_e   : transaction sequencer states
//   PORT_CORE : requester index of the multicycle core (port 0)
//   PORT_HOST : requester index of the external host (port 1)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant picker for the two requesters.
//   valid[1:0]   : request valids, index = port
//   last_grant   : port that won the previous handshake
//   grant_c[1:0] : one-hot grant, 0 when nobody requests
// Build option MEM_ARB_ROUND_ROBIN_EN: ties alternate away from last_grant;
// otherwise the core port wins every tie.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant_c
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // A lone requester's valid is already a one-hot grant.
  always_comb begin
    grant_c = valid;
    if (valid == 2'b11) begin
      grant_c = (last_grant == PORT_HOST) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_c = 2'b00;
    if (valid[PORT_CORE]) begin
      grant_c = 2'b01;
    end else if (valid[PORT_HOST]) begin
      grant_c = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/multicycle_mem_arbiter.sv
// Shares one single-ported fixed-latency memory between the multicycle core
// (m0) and an external host (m1), one transaction in flight at a time.
//   clock, reset       : rising-edge clock, async active-low reset
//   m0_* / m1_*        : request (valid/ready/address/write/data/mask) and
//                        response (rsp_valid strobe, read_data) per port
//   mem_*              : memory address, read/write strobes, write data/mask,
//                        read data returning MEM_LATENCY cycles after strobe
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (see mem_arb_grant); default is fixed priority to the core.
module multicycle_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m0_valid,
  output logic                    m0_ready,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic                    m0_write,
  input  logic [DATA_WIDTH-1:0]   m0_write_data,
  input  logic [DATA_WIDTH/8-1:0] m0_byte_mask,
  output logic                    m0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m0_read_data,
  input  logic                    m1_valid,
  output logic                    m1_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH-1:0]   m1_write_data,
  input  logic [DATA_WIDTH/8-1:0] m1_byte_mask,
  output logic                    m1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m1_read_data,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_read_en,
  output logic                    mem_write_en,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_byte_mask,
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);

  localparam int unsigned MASK_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    owner_q, owner_d;
  logic                    write_q, write_d;
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_write_data_q, mem_write_data_d;
  logic [MASK_W-1:0]       mem_byte_mask_q, mem_byte_mask_d;
  logic                    mem_read_en_q, mem_read_en_d;
  logic                    mem_write_en_q, mem_write_en_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0]   rd1_q, rd1_d;
  logic [1:0]              grant_c;
  logic                    sel_c;

  mem_arb_grant u_grant (
    .valid      ({m1_valid, m0_valid}),
    .last_grant (last_grant_q),
    .grant_c    (grant_c)
  );

  assign sel_c = grant_c[PORT_HOST] ? PORT_HOST : PORT_CORE;

  // Ready is a same-cycle handshake; held low while reset is asserted.
  assign m0_ready = reset && (state_q == IDLE) && grant_c[PORT_CORE];
  assign m1_ready = reset && (state_q == IDLE) && grant_c[PORT_HOST];

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    owner_d          = owner_q;
    write_d          = write_q;
    last_grant_d     = last_grant_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_byte_mask_d  = mem_byte_mask_q;
    mem_read_en_d    = 1'b0;
    mem_write_en_d   = 1'b0;
    rsp_valid_d      = 2'b00;
    rd0_d            = rd0_q;
    rd1_d            = rd1_q;

    case (state_q)
      IDLE: begin
        if (|grant_c) begin
          owner_d          = sel_c;
          last_grant_d     = sel_c;
          write_d          = sel_c ? m1_write      : m0_write;
          mem_address_d    = sel_c ? m1_address    : m0_address;
          mem_write_data_d = sel_c ? m1_write_data : m0_write_data;
          mem_byte_mask_d  = sel_c ? m1_byte_mask  : m0_byte_mask;
          // Strobes are registered so they appear during ACCESS.
          mem_read_en_d    = !write_d;
          mem_write_en_d   = write_d;
          state_d          = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Last wait cycle: read data is valid now; writes answer with 0.
          rsp_valid_d[owner_q] = 1'b1;
          if (owner_q == PORT_HOST) begin
            rd1_d = write_q ? '0 : mem_read_data;
          end else begin
            rd0_d = write_q ? '0 : mem_read_data;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; async reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      owner_q          <= PORT_CORE;
      write_q          <= 1'b0;
      last_grant_q     <= PORT_HOST;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_byte_mask_q  <= '0;
      mem_read_en_q    <= 1'b0;
      mem_write_en_q   <= 1'b0;
      rsp_valid_q      <= 2'b00;
      rd0_q            <= '0;
      rd1_q            <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      owner_q          <= owner_d;
      write_q          <= write_d;
      last_grant_q     <= last_grant_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_byte_mask_q  <= mem_byte_mask_d;
      mem_read_en_q    <= mem_read_en_d;
      mem_write_en_q   <= mem_write_en_d;
      rsp_valid_q      <= rsp_valid_d;
      rd0_q            <= rd0_d;
      rd1_q            <= rd1_d;
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_read_en    = mem_read_en_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_byte_mask  = mem_byte_mask_q;
  assign m0_rsp_valid   = rsp_valid_q[PORT_CORE];
  assign m1_rsp_valid   = rsp_valid_q[PORT_HOST];
  assign m0_read_data   = rd0_q;
  assign m1_read_data   = rd1_q;

endmodule

// File: tb/tb_multicycle_mem_arbiter.sv
// Directed bench for multicycle_mem_arbiter: instance a uses MEM_LATENCY=1,
// instance b uses MEM_LATENCY=3. Inputs change just after the falling edge,
// outputs are sampled mid-cycle. Define MEM_ARB_ROUND_ROBIN_EN to match the
// RTL build option.
module tb_multicycle_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory contents seen by both instances.
  function automatic logic [31:0] rdata_of(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return {addr[15:0], 16'hA5A5};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance a (latency 1) ----------------
  logic        a_m0_valid = 0, a_m0_write = 0, a_m1_valid = 0, a_m1_write = 0;
  logic [31:0] a_m0_address = 0, a_m0_write_data = 0, a_m1_address = 0, a_m1_write_data = 0;
  logic [3:0]  a_m0_byte_mask = 0, a_m1_byte_mask = 0;
  logic        a_m0_ready, a_m1_ready, a_m0_rsp_valid, a_m1_rsp_valid;
  logic [31:0] a_m0_read_data, a_m1_read_data;
  logic [31:0] a_mem_address, a_mem_write_data;
  logic [31:0] a_mem_read_data = 0;
  logic        a_mem_read_en, a_mem_write_en;
  logic [3:0]  a_mem_byte_mask;

  multicycle_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut_a (
    .clock(clk), .reset(rst_n),
    .m0_valid(a_m0_valid), .m0_ready(a_m0_ready), .m0_address(a_m0_address),
    .m0_write(a_m0_write), .m0_write_data(a_m0_write_data), .m0_byte_mask(a_m0_byte_mask),
    .m0_rsp_valid(a_m0_rsp_valid), .m0_read_data(a_m0_read_data),
    .m1_valid(a_m1_valid), .m1_ready(a_m1_ready), .m1_address(a_m1_address),
    .m1_write(a_m1_write), .m1_write_data(a_m1_write_data), .m1_byte_mask(a_m1_byte_mask),
    .m1_rsp_valid(a_m1_rsp_valid), .m1_read_data(a_m1_read_data),
    .mem_address(a_mem_address), .mem_read_en(a_mem_read_en), .mem_write_en(a_mem_write_en),
    .mem_write_data(a_mem_write_data), .mem_byte_mask(a_mem_byte_mask),
    .mem_read_data(a_mem_read_data)
  );

  // Read data is valid for exactly one cycle, one cycle after the strobe.
  always @(posedge clk) a_mem_read_data <= a_mem_read_en ? rdata_of(a_mem_address) : 32'h0;

  // ---------------- instance b (latency 3) ----------------
  logic        b_m0_valid = 0;
  logic [31:0] b_m0_address = 0;
  logic        b_m0_ready, b_m1_ready, b_m0_rsp_valid, b_m1_rsp_valid;
  logic [31:0] b_m0_read_data, b_m1_read_data;
  logic [31:0] b_mem_address, b_mem_write_data;
  logic        b_mem_read_en, b_mem_write_en;
  logic [3:0]  b_mem_byte_mask;
  logic [31:0] b_pipe0 = 0, b_pipe1 = 0, b_pipe2 = 0;

  multicycle_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut_b (
    .clock(clk), .reset(rst_n),
    .m0_valid(b_m0_valid), .m0_ready(b_m0_ready), .m0_address(b_m0_address),
    .m0_write(1'b0), .m0_write_data(32'h0), .m0_byte_mask(4'h0),
    .m0_rsp_valid(b_m0_rsp_valid), .m0_read_data(b_m0_read_data),
    .m1_valid(1'b0), .m1_ready(b_m1_ready), .m1_address(32'h0),
    .m1_write(1'b0), .m1_write_data(32'h0), .m1_byte_mask(4'h0),
    .m1_rsp_valid(b_m1_rsp_valid), .m1_read_data(b_m1_read_data),
    .mem_address(b_mem_address), .mem_read_en(b_mem_read_en), .mem_write_en(b_mem_write_en),
    .mem_write_data(b_mem_write_data), .mem_byte_mask(b_mem_byte_mask),
    .mem_read_data(b_pipe2)
  );

  always @(posedge clk) begin
    b_pipe0 <= b_mem_read_en ? rdata_of(b_mem_address) : 32'h0;
    b_pipe1 <= b_pipe0;
    b_pipe2 <= b_pipe1;
  end

  // One full latency-1 transaction on instance a, starting in the current cycle.
  task automatic run_txn(input string tag, input logic port, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [31:0] exp_rd);
    if (port) begin
      a_m1_valid = 1; a_m1_write = wr; a_m1_address = addr;
      a_m1_write_data = data; a_m1_byte_mask = mask;
    end else begin
      a_m0_valid = 1; a_m0_write = wr; a_m0_address = addr;
      a_m0_write_data = data; a_m0_byte_mask = mask;
    end
    #1;
    chk({tag, "_ready"}, {a_m1_ready, a_m0_ready}, port ? 2'b10 : 2'b01);
    @(negedge clk);
    a_m0_valid = 0; a_m1_valid = 0;
    a_m0_address = 32'hFFFF_FFFF; a_m1_address = 32'hFFFF_FFFF;
    chk({tag, "_strobe"}, {a_mem_read_en, a_mem_write_en}, wr ? 2'b01 : 2'b10);
    chk({tag, "_addr"}, a_mem_address, addr);
    if (wr) begin
      chk({tag, "_wdata"}, a_mem_write_data, data);
      chk({tag, "_mask"}, a_mem_byte_mask, mask);
    end
    @(negedge clk);
    chk({tag, "_wait"}, {a_mem_read_en, a_mem_write_en, a_m1_rsp_valid, a_m0_rsp_valid}, 4'b0000);
    @(negedge clk);
    chk({tag, "_rsp"}, {a_m1_rsp_valid, a_m0_rsp_valid}, port ? 2'b10 : 2'b01);
    chk({tag, "_rdata"}, port ? a_m1_read_data : a_m0_read_data, exp_rd);
    @(negedge clk);
    chk({tag, "_rsp_end"}, {a_m1_rsp_valid, a_m0_rsp_valid}, 2'b00);
    chk({tag, "_hold"}, port ? a_m1_read_data : a_m0_read_data, exp_rd);
  endtask

  logic [1:0] exp_gnt [3];

  initial begin
    // Reset held: everything quiet even with a request pending.
    a_m0_valid = 1; a_m0_address = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {a_m1_ready, a_m0_ready}, 2'b00);
    chk("rst_strobe", {a_mem_read_en, a_mem_write_en, b_mem_read_en, b_mem_write_en}, 4'b0000);
    chk("rst_rsp", {a_m1_rsp_valid, a_m0_rsp_valid, b_m1_rsp_valid, b_m0_rsp_valid}, 4'b0000);
    chk("rst_mem_regs", {a_mem_address, a_mem_write_data}, 64'h0);
    chk("rst_b_regs", {b_mem_write_data, 28'h0, b_mem_byte_mask}, 64'h0);
    chk("rst_rdata", {a_m0_read_data, a_m1_read_data}, 64'h0);
    rst_n = 1;

    // Read accepted on the first edge after release.
    run_txn("rd_m0", 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
    run_txn("rd_m1", 1'b1, 1'b0, 32'h180, 32'h0, 4'h0, rdata_of(32'h180));
    run_txn("wr_m1", 1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011, 32'h0);
    chk("wr_m0_untouched", a_m0_read_data, 32'hDEADBEEF);

    // Tie: both requesters hold valid across three accept slots.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
`else
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01;
`endif
    a_m0_valid = 1; a_m0_write = 0; a_m0_address = 32'h300;
    a_m1_valid = 1; a_m1_write = 0; a_m1_address = 32'h400;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tie%0d_grant", i), {a_m1_ready, a_m0_ready}, exp_gnt[i]);
      @(negedge clk);
      if (i == 2) begin a_m0_valid = 0; a_m1_valid = 0; end
      chk($sformatf("tie%0d_busy", i), {a_m1_ready, a_m0_ready}, 2'b00);
      repeat (2) @(negedge clk);
      chk($sformatf("tie%0d_rsp", i), {a_m1_rsp_valid, a_m0_rsp_valid}, exp_gnt[i]);
      chk($sformatf("tie%0d_rdata", i), exp_gnt[i][1] ? a_m1_read_data : a_m0_read_data,
          rdata_of(exp_gnt[i][1] ? 32'h400 : 32'h300));
      @(negedge clk);
      #1;
    end

    // Reset during WAIT: transaction dropped, no response.
    a_m0_valid = 1; a_m0_write = 0; a_m0_address = 32'h500;
    @(negedge clk);
    a_m0_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_strobe", {a_mem_read_en, a_mem_write_en}, 2'b00);
    chk("midrst_rdata_clr", a_m0_read_data, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_rsp", {a_m1_rsp_valid, a_m0_rsp_valid}, 2'b00);
    end
    rst_n = 1;
    @(negedge clk);
    chk("midrst_no_rsp_after", {a_m1_rsp_valid, a_m0_rsp_valid}, 2'b00);
    run_txn("post_rst", 1'b0, 1'b0, 32'h104, 32'h0, 4'h0, rdata_of(32'h104));

    // Latency 3: valid held high, ready must stay low T+1..T+5.
    b_m0_valid = 1; b_m0_address = 32'h40;
    #1;
    chk("l3_ready", b_m0_ready, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) b_m0_valid = 0;
      chk($sformatf("l3_ready_t%0d", k), b_m0_ready, 1'b0);
      chk($sformatf("l3_rden_t%0d", k), b_mem_read_en, k == 1);
      chk($sformatf("l3_rsp_t%0d", k), {b_m1_rsp_valid, b_m0_rsp_valid}, (k == 5) ? 2'b01 : 2'b00);
    end
    chk("l3_rdata", b_m0_read_data, rdata_of(32'h40));
    chk("l3_m1_rdata", {b_m1_ready, b_mem_write_en, b_m1_read_data}, 34'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
